// File: rtl/instr_walker_pkg.sv
// Shared types and constants for the instruction-side page walker and its iTLB.
package instr_walker_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WALK_REQ,
    WALK_WAIT,
    RESP,
    DRAIN
  } walk_state_e;

  localparam int unsigned PTE_V       = 0;
  localparam int unsigned PTE_L       = 1;
  localparam int unsigned PTE_X       = 2;
  localparam int unsigned PTE_PPN_LSB = 10;

  function automatic int unsigned idx_w(input int unsigned va_w, input int unsigned page_bits,
                                        input int unsigned levels);
    return (va_w - page_bits) / levels;
  endfunction

  function automatic int unsigned ppn_w(input int unsigned pa_w, input int unsigned page_bits);
    return pa_w - page_bits;
  endfunction

  localparam int unsigned DEF_VA_W        = 32;
  localparam int unsigned DEF_PA_W        = 32;
  localparam int unsigned DEF_PAGE_BITS   = 12;
  localparam int unsigned DEF_LEVELS      = 2;
  localparam int unsigned DEF_TLB_ENTRIES = 4;
  localparam int unsigned DEF_PTE_W       = 32;

  localparam int unsigned TLB_VPN_W = DEF_VA_W - DEF_PAGE_BITS;
  localparam int unsigned TLB_PPN_W = ppn_w(DEF_PA_W, DEF_PAGE_BITS);

  // lvl_mask marks the low PPN bits supplied by the VPN (superpage span)
  typedef struct packed {
    logic                 valid;
    logic [TLB_VPN_W-1:0] vpn;
    logic [TLB_PPN_W-1:0] ppn;
    logic [TLB_PPN_W-1:0] lvl_mask;
  } tlb_entry_t;

endpackage

// File: rtl/instr_tlb_cam.sv
// Fully-associative iTLB: parallel tag match with superpage masking, round-robin fill, flush.
module instr_tlb_cam
  import instr_walker_pkg::*;
#(
  parameter int unsigned ENTRIES = DEF_TLB_ENTRIES
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush_i,
  input  logic [TLB_VPN_W-1:0] lookup_vpn_i,
  output logic                 hit_c_o,
  output logic [TLB_PPN_W-1:0] ppn_c_o,
  input  logic                 fill_i,
  input  logic [TLB_VPN_W-1:0] fill_vpn_i,
  input  logic [TLB_PPN_W-1:0] fill_ppn_i,
  input  logic [TLB_PPN_W-1:0] fill_mask_i
);

  localparam int unsigned PTR_W = (ENTRIES > 1) ? $clog2(ENTRIES) : 1;

  tlb_entry_t       entries_q [ENTRIES];
  logic [PTR_W-1:0] ptr_q;

  // Flush takes priority over a same-cycle fill
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(ENTRIES); i++) entries_q[i].valid <= 1'b0;
      ptr_q <= '0;
    end else if (flush_i) begin
      for (int i = 0; i < int'(ENTRIES); i++) entries_q[i].valid <= 1'b0;
    end else if (fill_i) begin
      entries_q[ptr_q] <= '{valid: 1'b1, vpn: fill_vpn_i, ppn: fill_ppn_i, lvl_mask: fill_mask_i};
      ptr_q            <= ptr_q + PTR_W'(1);
    end
  end

  // Lowest matching index wins if a superpage overlaps a smaller page
  always_comb begin
    hit_c_o = 1'b0;
    ppn_c_o = '0;
    for (int i = int'(ENTRIES) - 1; i >= 0; i--) begin
      if (entries_q[i].valid &&
          (((entries_q[i].vpn ^ lookup_vpn_i) & ~TLB_VPN_W'(entries_q[i].lvl_mask)) == '0)) begin
        hit_c_o = 1'b1;
        ppn_c_o = (entries_q[i].ppn & ~entries_q[i].lvl_mask) |
                  (TLB_PPN_W'(lookup_vpn_i) & entries_q[i].lvl_mask);
      end
    end
  end

endmodule

// File: rtl/instr_page_walker_ml.sv
// Multi-level instruction page walker: iTLB lookup, PTE walk, kill/drain and flush handling.
module instr_page_walker_ml
  import instr_walker_pkg::*;
#(
  parameter int unsigned VA_W        = DEF_VA_W,
  parameter int unsigned PA_W        = DEF_PA_W,
  parameter int unsigned PAGE_BITS   = DEF_PAGE_BITS,
  parameter int unsigned LEVELS      = DEF_LEVELS,
  parameter int unsigned TLB_ENTRIES = DEF_TLB_ENTRIES,
  parameter int unsigned PTE_W       = DEF_PTE_W
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                xlat_en,
  input  logic [ppn_w(PA_W, PAGE_BITS)-1:0]   root_ppn,
  input  logic                                tlb_flush,
  input  logic                                kill,
  input  logic                                req_valid,
  output logic                                req_ready,
  input  logic [VA_W-1:0]                     req_vpc,
  output logic                                rsp_valid,
  input  logic                                rsp_ready,
  output logic [PA_W-1:0]                     rsp_ppc,
  output logic                                rsp_fault,
  output logic                                mem_req_valid,
  input  logic                                mem_req_ready,
  output logic [PA_W-1:0]                     mem_req_addr,
  input  logic                                mem_rsp_valid,
  input  logic [PTE_W-1:0]                    mem_rsp_data
);

  localparam int unsigned IDX_W = idx_w(VA_W, PAGE_BITS, LEVELS);
  localparam int unsigned PPN_W = ppn_w(PA_W, PAGE_BITS);
  localparam int unsigned VPN_W = VA_W - PAGE_BITS;
  localparam int unsigned LVL_W = (LEVELS > 1) ? $clog2(LEVELS) : 1;

  walk_state_e      state_q, state_d;
  logic [VA_W-1:0]  vpc_q, vpc_d;
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [PPN_W-1:0] base_q, base_d;
  logic             flush_pend_q, flush_pend_d;
  logic             req_ready_q, req_ready_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic             rsp_fault_q, rsp_fault_d;
  logic [PA_W-1:0]  rsp_ppc_q, rsp_ppc_d;
  logic             mem_req_valid_q, mem_req_valid_d;
  logic [PA_W-1:0]  mem_req_addr_q, mem_req_addr_d;

  logic             tlb_hit_c, tlb_fill_c;
  logic [PPN_W-1:0] tlb_ppn_c, pte_ppn_c, lvl_mask_c, leaf_ppn_c;
  logic [VPN_W-1:0] vpn_q_c;
  logic             pte_v_c, pte_l_c, pte_x_c, misaligned_c, pte_unused;

  function automatic logic [PA_W-1:0] pte_addr(input logic [PPN_W-1:0] base,
                                               input logic [VA_W-1:0]  vpc,
                                               input logic [LVL_W-1:0] lvl);
    logic [IDX_W-1:0] idx;
    idx = vpc[PAGE_BITS + 32'(lvl) * IDX_W +: IDX_W];
    return PA_W'({base, idx, 2'b00});
  endfunction

  assign pte_v_c      = mem_rsp_data[PTE_V];
  assign pte_l_c      = mem_rsp_data[PTE_L];
  assign pte_x_c      = mem_rsp_data[PTE_X];
  assign pte_ppn_c    = mem_rsp_data[PTE_PPN_LSB +: PPN_W];
  assign pte_unused   = ^mem_rsp_data;
  assign vpn_q_c      = vpc_q[PAGE_BITS +: VPN_W];
  assign lvl_mask_c   = ~({PPN_W{1'b1}} << (32'(lvl_q) * IDX_W));
  assign misaligned_c = |(pte_ppn_c & lvl_mask_c);
  assign leaf_ppn_c   = (pte_ppn_c & ~lvl_mask_c) | (PPN_W'(vpn_q_c) & lvl_mask_c);

  instr_tlb_cam #(.ENTRIES(TLB_ENTRIES)) u_tlb (
    .clk          (clk),
    .rst          (rst),
    .flush_i      (tlb_flush),
    .lookup_vpn_i (req_vpc[PAGE_BITS +: VPN_W]),
    .hit_c_o      (tlb_hit_c),
    .ppn_c_o      (tlb_ppn_c),
    .fill_i       (tlb_fill_c),
    .fill_vpn_i   (vpn_q_c),
    .fill_ppn_i   (leaf_ppn_c),
    .fill_mask_i  (lvl_mask_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      vpc_q           <= '0;
      lvl_q           <= '0;
      base_q          <= '0;
      flush_pend_q    <= 1'b0;
      req_ready_q     <= 1'b1;
      rsp_valid_q     <= 1'b0;
      rsp_fault_q     <= 1'b0;
      rsp_ppc_q       <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      state_q         <= state_d;
      vpc_q           <= vpc_d;
      lvl_q           <= lvl_d;
      base_q          <= base_d;
      flush_pend_q    <= flush_pend_d;
      req_ready_q     <= req_ready_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_fault_q     <= rsp_fault_d;
      rsp_ppc_q       <= rsp_ppc_d;
      mem_req_valid_q <= mem_req_valid_d;
      mem_req_addr_q  <= mem_req_addr_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    vpc_d          = vpc_q;
    lvl_d          = lvl_q;
    base_d         = base_q;
    flush_pend_d   = flush_pend_q;
    rsp_fault_d    = rsp_fault_q;
    rsp_ppc_d      = rsp_ppc_q;
    mem_req_addr_d = mem_req_addr_q;
    tlb_fill_c     = 1'b0;

    if (tlb_flush && (state_q == WALK_REQ || state_q == WALK_WAIT)) flush_pend_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (req_valid && !kill) begin
          vpc_d       = req_vpc;
          rsp_fault_d = 1'b0;
          if (!xlat_en) begin
            state_d   = RESP;
            rsp_ppc_d = PA_W'(req_vpc);
          end else if (tlb_hit_c) begin
            state_d   = RESP;
            rsp_ppc_d = PA_W'({tlb_ppn_c, req_vpc[PAGE_BITS-1:0]});
          end else begin
            state_d      = WALK_REQ;
            lvl_d        = LVL_W'(LEVELS - 1);
            base_d       = root_ppn;
            flush_pend_d = 1'b0;
          end
        end
      end
      WALK_REQ: begin
        if (mem_req_ready) state_d = kill ? DRAIN : WALK_WAIT;
        else if (kill)     state_d = IDLE;
      end
      WALK_WAIT: begin
        if (mem_rsp_valid) begin
          if (kill) begin
            state_d = IDLE;
          end else if (!pte_v_c || (pte_l_c && (!pte_x_c || misaligned_c)) ||
                       (!pte_l_c && lvl_q == '0)) begin
            state_d     = RESP;
            rsp_fault_d = 1'b1;
            rsp_ppc_d   = '0;
          end else if (!pte_l_c) begin
            state_d = WALK_REQ;
            base_d  = pte_ppn_c;
            lvl_d   = lvl_q - LVL_W'(1);
          end else begin
            state_d    = RESP;
            rsp_ppc_d  = PA_W'({leaf_ppn_c, vpc_q[PAGE_BITS-1:0]});
            tlb_fill_c = !flush_pend_q;
          end
        end else if (kill) begin
          state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (mem_rsp_valid) state_d = IDLE;
      end
      RESP: begin
        if (kill || rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (state_d == WALK_REQ) mem_req_addr_d = pte_addr(base_d, vpc_d, lvl_d);
    req_ready_d     = (state_d == IDLE);
    rsp_valid_d     = (state_d == RESP);
    mem_req_valid_d = (state_d == WALK_REQ);
  end

  assign req_ready     = req_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_fault     = rsp_fault_q;
  assign rsp_ppc       = rsp_ppc_q;
  assign mem_req_valid = mem_req_valid_q;
  assign mem_req_addr  = mem_req_addr_q;

endmodule

// File: doc/instr_page_walker_ml.md
Name: instr_page_walker_ml

Overview:
Parametrised multi-level instruction-side page walker with a small fully-associative iTLB. It sits between the PC generator and the instruction loader, taking a virtual PC and issuing a physical PC or a fetch fault. It generalises the single-level walker in level count, TLB depth, address widths and superpage support, and adds kill/flush handling and bare (untranslated) mode.

Parameters:
VA_W, 32, virtual PC width
PA_W, 32, physical address width
PAGE_BITS, 12, page offset bits; must equal IDX_W+2
LEVELS, 2, page-table levels; IDX_W = (VA_W-PAGE_BITS)/LEVELS
TLB_ENTRIES, 4, iTLB entries, power of two, ≥2
PTE_W, 32, PTE width; PPN_W = PA_W-PAGE_BITS must fit in pte[10 +: PPN_W]

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
xlat_en  in  1  1 = translate, 0 = bare mode
root_ppn  in  PPN_W  root table PPN, sampled at walk start
tlb_flush  in  1  one-cycle pulse: invalidate all iTLB entries
kill  in  1  abandon the current request (redirect)
req_valid  in  1  PC request valid
req_ready  out  1  walker can accept a request
req_vpc  in  VA_W  virtual PC
rsp_valid  out  1  response valid
rsp_ready  in  1  loader accepts response
rsp_ppc  out  PA_W  physical PC
rsp_fault  out  1  fetch page fault
mem_req_valid  out  1  PTE read request
mem_req_ready  in  1  memory accepts request
mem_req_addr  out  PA_W  PTE byte address
mem_rsp_valid  in  1  PTE data valid; no backpressure, exactly one per accepted request
mem_rsp_data  in  PTE_W  PTE

Behaviour:
- Reset: FSM=IDLE; all TLB valid bits 0; replacement pointer 0; req_ready=1; rsp_valid=0; rsp_fault=0; mem_req_valid=0; rsp_ppc=0; mem_req_addr=0.
- States: IDLE, WALK_REQ, WALK_WAIT, RESP, DRAIN.
- IDLE: req_ready=1. A handshake latches vpc.
  - xlat_en=0: go to RESP with ppc = vpc truncated/zero-extended to PA_W, fault=0. Latency 1.
  - TLB hit (valid && vpn match): go to RESP with {ppn, offset}. Latency 1.
  - Miss: lvl=LEVELS-1, base=root_ppn, go to WALK_REQ.
- WALK_REQ: mem_req_valid=1, mem_req_addr={base, vpn_idx[lvl], 2'b00} truncated to PA_W. On mem_req_ready go to WALK_WAIT.
- WALK_WAIT: on mem_rsp_valid decode the PTE. Bit0=V, bit1=L (leaf), bit2=X, PPN=pte[10 +: PPN_W].
  - V=0: fault.
  - Leaf with X=0: fault.
  - Leaf at lvl>0 whose low lvl*IDX_W PPN bits are not 0 (misaligned superpage): fault.
  - Non-leaf at lvl=0: fault.
  - Non-leaf otherwise: base=PPN, lvl--, go to WALK_REQ.
  - Valid leaf: ppn = PPN with the low lvl*IDX_W bits replaced by VPN bits. Fill the TLB at the replacement pointer (stores VPN, PPN and level mask). Pointer increments modulo TLB_ENTRIES. Go to RESP.
  - Faults go to RESP with fault=1, rsp_ppc={vpc-derived 0}=0, and no TLB fill.
- RESP: rsp_valid held with stable data until rsp_ready, then IDLE. req_ready=0 outside IDLE.
- Hit latency is 1 cycle. Miss latency is 1 + Σ(mem latency) over the levels walked.
- kill:
  - In IDLE it blocks acceptance that cycle.
  - In WALK_REQ before the handshake, or in RESP, go to IDLE; rsp_valid drops next cycle.
  - In WALK_REQ with the same-cycle handshake, or in WALK_WAIT, go to DRAIN. DRAIN swallows the single outstanding mem_rsp, then goes to IDLE. A kill in the same cycle as mem_rsp_valid goes straight to IDLE.
  - The killed result never fills the TLB.
- tlb_flush: clears all valid bits the next cycle.
  - Sets a flush_pending flag if it occurs during a walk; that walk's fill is suppressed but its response is still delivered.
  - Flush and fill in the same cycle: flush wins.
  - Flush in IDLE with a same-cycle lookup: the lookup uses the pre-flush contents.
- Priority within a cycle: rst > kill > normal.
- Never more than one outstanding memory request.

Decomposition:
- Package instr_walker_pkg:
  - state enum
  - PTE bit-position constants (PTE_V=0, PTE_L=1, PTE_X=2, PTE_PPN_LSB=10)
  - functions computing IDX_W/PPN_W
  - tlb_entry_t struct (valid, vpn, ppn, lvl_mask)
- One sub-module, instr_tlb_cam:
  - entry array and parallel match
  - hit/ppn output with superpage masking
  - round-robin fill pointer and flush

Test Plan:
- Bare mode: xlat_en=0, vpc=0x0000_1234 → rsp_valid 1 cycle after accept, ppc=0x0000_1234, fault=0, no mem_req.
- Two-level walk: root_ppn=0x80000, vpc=0x0040_1234.
  - Request 1: mem_req_addr=0x8000_0004, return PTE{PPN=0x80001,V}.
  - Request 2: addr=0x8000_1004, return PTE{PPN=0x12345,V,L,X}.
  - Response: ppc=0x1234_5234, fault=0. Repeat of the same vpc → hit in 1 cycle, no mem_req.
- Superpage: level-1 leaf PPN=0x40000 for vpc=0x0040_1ABC → ppc=0x4000_1ABC. Leaf PPN=0x40001 → fault=1, TLB unchanged.
- Faults: V=0 PTE → fault=1. Leaf with X=0 → fault=1. Non-leaf at level 0 → fault=1. Subsequent same vpc misses again.
- Kill in WALK_WAIT: then mem_rsp arrives 3 cycles later → no rsp_valid, req_ready returns 1 after the drain, TLB not filled.
- Flush mid-walk: response still delivered with the correct ppc, repeat lookup misses. Five distinct pages fill and evict entry 0 round-robin (TLB_ENTRIES=4).
